// File: rtl/seg_scan_decoder.sv
// Recovers the two 2-digit scores from a multiplexed active-low 7-segment bus.
// Each digit is accepted only after the bus has held one pattern for SETTLE_CYCLES samples.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 2000000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [7:0] anode,
    input  logic [6:0] segment,
    output logic [5:0] wins1,
    output logic [5:0] wins2,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       stale
);

    localparam int unsigned CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    state_t          state_q, state_d;
    logic [14:0]     sync1_q, samp_q, prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      seen_q, seen_d;
    logic [5:0]      wins1_q, wins1_d, wins2_q, wins2_d;
    logic            fv_q, fv_d, err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            changed, capture;
    logic [7:0]      cap_an;
    logic [6:0]      cap_seg;
    logic            blank, onehot, dig_ok, slot_ok, cap_err, cap_store;
    logic [3:0]      dig;
    logic [1:0]      slot;
    logic            all_seen, range_bad, frame_good;
    logic [6:0]      t1, t2;

    assign changed = (samp_q != prev_q);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (changed) begin
            state_d = SETTLE;
        end else if (state_q == SETTLE && cnt_q == CNT_MAX) begin
            state_d = CAPTURED;
        end
    end

    // prev_q is the pattern that has just been stable long enough, even if S moves this cycle
    always_comb begin
        capture = (state_q == SETTLE) && (cnt_q == CNT_MAX);
    end

    always_comb begin
        cap_an  = prev_q[14:7];
        cap_seg = prev_q[6:0];
        blank   = (cap_an == 8'hFF);
        onehot  = $onehot(~cap_an);
        dig_ok  = 1'b1;
        dig     = '0;
        case (cap_seg)
            7'h40: dig = 4'd0;
            7'h79: dig = 4'd1;
            7'h24: dig = 4'd2;
            7'h30: dig = 4'd3;
            7'h19: dig = 4'd4;
            7'h12: dig = 4'd5;
            7'h02: dig = 4'd6;
            7'h78: dig = 4'd7;
            7'h00: dig = 4'd8;
            7'h10: dig = 4'd9;
            default: dig_ok = 1'b0;
        endcase
        slot_ok = 1'b1;
        slot    = '0;
        case (cap_an)
            8'b1111_1110: slot = 2'd0;
            8'b1111_1101: slot = 2'd1;
            8'b1110_1111: slot = 2'd2;
            8'b1101_1111: slot = 2'd3;
            default:      slot_ok = 1'b0;
        endcase
        cap_err   = capture && !blank && !(onehot && dig_ok);
        cap_store = capture && slot_ok && dig_ok;
    end

    always_comb begin
        all_seen   = &seen_q;
        t1         = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
        t2         = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);
        range_bad  = all_seen && (t1 > 7'd63 || t2 > 7'd63);
        frame_good = all_seen && !range_bad;

        cnt_d = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

        // a capture landing on the clearing cycle keeps its own seen bit
        seen_d = all_seen ? '0 : seen_q;
        dig_d  = dig_q;
        if (cap_store) begin
            seen_d[slot] = 1'b1;
            dig_d[slot]  = dig;
        end

        fv_d    = frame_good;
        err_d   = cap_err || range_bad;
        wins1_d = frame_good ? t1[5:0] : wins1_q;
        wins2_d = frame_good ? t2[5:0] : wins2_q;
        timer_d = frame_good ? '0 : ((timer_q >= TMO) ? timer_q : timer_q + 1'b1);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            samp_q  <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            seen_q  <= '0;
            wins1_q <= '0;
            wins2_q <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            sync1_q <= {anode, segment};
            samp_q  <= sync1_q;
            prev_q  <= samp_q;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            seen_q  <= seen_d;
            wins1_q <= wins1_d;
            wins2_q <= wins2_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign wins1       = wins1_q;
    assign wins2       = wins2_q;
    assign frame_valid = fv_q;
    assign decode_err  = err_q;
    assign stale       = (timer_q >= TMO);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a digit-level model predicts frame/error events,
// a monitor pops them whenever the DUT pulses frame_valid or decode_err.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned TMO    = 1000;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic [7:0] anode;
    logic [6:0] segment;
    logic [5:0] wins1, wins2;
    logic       frame_valid, decode_err, stale;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .anode      (anode),
        .segment    (segment),
        .wins1      (wins1),
        .wins2      (wins2),
        .frame_valid(frame_valid),
        .decode_err (decode_err),
        .stale      (stale)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic       is_err;
        logic [5:0] w1;
        logic [5:0] w2;
    } ev_t;

    ev_t q[$];
    int  compared   = 0;
    int  mismatched = 0;

    logic [6:0]  segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int          mdig [4];
    bit          mseen [4];
    logic [5:0]  exp_w1, exp_w2;
    logic [14:0] last;

    task automatic check(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int seg2dig(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (segtab[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin mdig[i] = 0; mseen[i] = 0; end
        exp_w1 = '0;
        exp_w2 = '0;
    endtask

    // Digit-level view: an accepted pattern either errs, is ignored, or fills a score digit.
    task automatic model_capture(input logic [7:0] an, input logic [6:0] sg);
        int d, pos, slot, t1, t2;
        if (an == 8'hFF) return;
        d = seg2dig(sg);
        if ($countones(~an) != 1 || d < 0) begin
            q.push_back('{1'b1, exp_w1, exp_w2});
            return;
        end
        pos = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) pos = i + 1;
        case (pos)
            1: slot = 0;
            2: slot = 1;
            5: slot = 2;
            6: slot = 3;
            default: return;
        endcase
        mdig[slot]  = d;
        mseen[slot] = 1;
        if (mseen[0] && mseen[1] && mseen[2] && mseen[3]) begin
            t1 = mdig[0] * 10 + mdig[1];
            t2 = mdig[2] * 10 + mdig[3];
            for (int i = 0; i < 4; i++) mseen[i] = 0;
            if (t1 > 63 || t2 > 63) begin
                q.push_back('{1'b1, exp_w1, exp_w2});
            end else begin
                exp_w1 = 6'(t1);
                exp_w2 = 6'(t2);
                q.push_back('{1'b0, exp_w1, exp_w2});
            end
        end
    endtask

    task automatic hold(input logic [7:0] an, input logic [6:0] sg, input int dur);
        @(posedge clk_100MHz); #1;
        anode   = an;
        segment = sg;
        last    = {an, sg};
        if (dur >= SETTLE + 2) model_capture(an, sg);
        repeat (dur - 1) @(posedge clk_100MHz);
    endtask

    function automatic logic [7:0] pos_an(input int p);
        logic [7:0] a;
        a = 8'hFF;
        a[p-1] = 1'b0;
        return a;
    endfunction

    task automatic digit(input int p, input int d, input int dur);
        hold(pos_an(p), segtab[d], dur);
    endtask

    task automatic do_reset();
        @(posedge clk_100MHz); #1;
        rst_n   = 1'b0;
        anode   = 8'hFF;
        segment = 7'h7F;
        #1;
        check("async_reset_wins1", wins1, 0);
        check("async_reset_wins2", wins2, 0);
        check("reset_queue_empty", q.size(), 0);
        q.delete();
        model_reset();
        repeat (3) @(posedge clk_100MHz);
        #1 rst_n = 1'b1;
        last = {8'hFF, 7'h7F};
    endtask

    always @(negedge clk_100MHz) begin
        if (rst_n && (frame_valid || decode_err)) begin
            ev_t e;
            check("fv_err_exclusive", int'(frame_valid && decode_err), 0);
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got fv=%0d err=%0d expected none", frame_valid, decode_err);
            end else begin
                e = q.pop_front();
                check("event_is_err", decode_err, e.is_err);
                check("wins1", wins1, e.w1);
                check("wins2", wins2, e.w2);
                if (frame_valid) check("stale_on_frame", stale, 0);
            end
        end
    end

    initial begin
        logic [7:0] an;
        logic [6:0] sg;
        int kind, dur, a, b;
        int plist[6] = '{1, 2, 5, 6, 3, 7};

        rst_n   = 1'b0;
        anode   = 8'hFF;
        segment = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("reset_wins1", wins1, 0);
        check("reset_wins2", wins2, 0);
        check("reset_fv", frame_valid, 0);
        check("reset_err", decode_err, 0);
        check("reset_stale", stale, 0);
        #1 rst_n = 1'b1;
        last = {8'hFF, 7'h7F};

        // 17 / 09 frame
        digit(1, 1, 100); digit(2, 7, 100); digit(5, 0, 100); digit(6, 9, 100);
        hold(8'hFF, 7'h7F, 40);

        // too short to settle, then long enough idle to go stale
        for (int i = 0; i < 3; i++) begin
            digit(1, 3, 10); digit(2, 4, 10); digit(5, 5, 10); digit(6, 6, 10);
        end
        hold(8'hFF, 7'h7F, TMO + 50);
        @(negedge clk_100MHz);
        check("stale_after_timeout", stale, 1);

        // illegal patterns
        hold(8'b1111_1100, 7'h40, 50);
        hold(pos_an(1), 7'h7F, 50);

        // 64 out of range
        digit(1, 6, 50); digit(2, 4, 50); digit(5, 1, 50); digit(6, 1, 50);
        hold(8'hFF, 7'h7F, 40);

        // mid-frame reset, then 42 / 05
        digit(1, 9, 50); digit(2, 9, 50);
        do_reset();
        digit(1, 4, 50); digit(2, 2, 50); digit(5, 0, 50); digit(6, 5, 50);
        hold(8'hFF, 7'h7F, TMO + 50);
        @(negedge clk_100MHz);
        check("stale_before_blank_frame", stale, 1);

        // blanks and positions 3/4 interleaved, 23 / 31
        digit(1, 2, 30); hold(8'hFF, 7'h7F, 30); digit(3, 8, 30); hold(8'hFF, 7'h7F, 30);
        digit(2, 3, 30); hold(8'hFF, 7'h7F, 30); digit(4, 1, 30); hold(8'hFF, 7'h7F, 30);
        digit(5, 3, 30); hold(8'hFF, 7'h7F, 30); digit(6, 1, 30); hold(8'hFF, 7'h7F, 40);
        @(negedge clk_100MHz);
        check("stale_cleared_by_frame", stale, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            do begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    an = 8'hFF; sg = 7'h7F;
                end else if (kind == 1) begin
                    a = $urandom_range(0, 7);
                    do b = $urandom_range(0, 7); while (b == a);
                    an = 8'hFF; an[a] = 1'b0; an[b] = 1'b0;
                    sg = segtab[$urandom_range(0, 9)];
                end else if (kind == 2) begin
                    an = pos_an($urandom_range(1, 8));
                    do sg = 7'($urandom_range(0, 127)); while (seg2dig(sg) >= 0);
                end else begin
                    an = pos_an(plist[$urandom_range(0, 5)]);
                    sg = segtab[(kind > 6) ? $urandom_range(0, 5) : $urandom_range(0, 9)];
                end
            end while ({an, sg} == last);
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(18, 40);
            hold(an, sg, dur);
        end

        hold(8'hFF, 7'h7F, 60);
        @(negedge clk_100MHz);
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
